mem_access_unit: RTL and testbench

Memory-stage unit sitting on the read side of the EX/MEM pipeline register. It consumes the registered EX/MEM control and data fields, runs loads and stores over a req/ack data-memory handshake, and stalls the front of the pipeline while an access is outstanding. It also resolves branch and jump redirects, and drives the MEM/WB pipeline register with either the writeback payload or a bubble.

---
 rtl/pipeline_pkg.sv | 22 ++
 rtl/dmem_handshake_fsm.sv | 106 ++++++++++
 rtl/mem_access_unit.sv | 131 +++++++++++++
 tb/tb_mem_access_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared encodings for the memory stage: writeback select, PC redirect select
// and the data-memory handshake state.
package pipeline_pkg;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC  = 2'b10
  } wb_sel_t;

  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,
    PC_IMM = 2'b01,
    PC_REG = 2'b10
  } pc_src_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/dmem_handshake_fsm.sv
// Data-memory req/ack sequencer: launches one access per load/store, waits for
// ack or aborts after TIMEOUT WAIT cycles, and produces the pipeline stall term.
module dmem_handshake_fsm
  import pipeline_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] alu_out,
  input  logic [31:0] read_data_2,
  input  logic        dmem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        stall,
  output logic        ack_accept,
  output logic        abort,
  output logic        bus_err
);

  localparam int CW = $clog2(TIMEOUT);

  mem_state_t    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          bus_err_q, bus_err_d;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    bus_err_d  = 1'b0;
    stall      = 1'b0;
    ack_accept = 1'b0;
    abort      = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_read | mem_write) begin
          stall   = 1'b1;
          state_d = WAIT;
          count_d = '0;
          req_d   = 1'b1;
          we_d    = mem_write;
          addr_d  = alu_out;
          wdata_d = read_data_2;
        end
      end
      WAIT: begin
        // Ack takes priority over a timeout landing in the same cycle.
        if (dmem_ack) begin
          ack_accept = 1'b1;
          state_d    = IDLE;
          req_d      = 1'b0;
          we_d       = 1'b0;
        end else if (count_q == CW'(TIMEOUT - 1)) begin
          abort     = 1'b1;
          state_d   = IDLE;
          req_d     = 1'b0;
          we_d      = 1'b0;
          bus_err_d = 1'b1;
        end else begin
          stall   = 1'b1;
          count_d = count_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign bus_err    = bus_err_q;

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: data-memory access, branch/jump redirect and MEM/WB register.
// Stalls the front end while an access is outstanding; bubbles MEM/WB meanwhile.
module mem_access_unit
  import pipeline_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ex_mem_rd,
  input  logic        reg_write,
  input  logic [1:0]  mem_reg_pc,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        jl,
  input  logic        jlr,
  input  logic        branch,
  input  logic [31:0] pc_inc,
  input  logic [31:0] pc_plus_imm,
  input  logic [31:0] alu_out,
  input  logic [31:0] read_data_2,
  input  logic        zero,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall,
  output logic [1:0]  pc_src,
  output logic [31:0] pc_target,
  output logic        flush,
  output logic        bus_err,
  output logic [4:0]  mem_wb_rd,
  output logic        mem_wb_reg_write,
  output logic [1:0]  mem_wb_mem_reg_pc,
  output logic [31:0] mem_wb_alu_out,
  output logic [31:0] mem_wb_read_data,
  output logic [31:0] mem_wb_pc_inc
);

  logic    ack_accept;
  logic    abort;
  pc_src_t pc_sel;

  dmem_handshake_fsm #(
    .TIMEOUT (TIMEOUT)
  ) u_fsm (
    .clk         (clk),
    .reset       (reset),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .alu_out     (alu_out),
    .read_data_2 (read_data_2),
    .dmem_ack    (dmem_ack),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .stall       (stall),
    .ack_accept  (ack_accept),
    .abort       (abort),
    .bus_err     (bus_err)
  );

  always_comb begin
    pc_sel    = PC_SEQ;
    pc_target = pc_inc;
    if (jlr) begin
      pc_sel    = PC_REG;
      pc_target = {alu_out[31:1], 1'b0};
    end else if (jl | (branch & zero)) begin
      pc_sel    = PC_IMM;
      pc_target = pc_plus_imm;
    end
  end

  assign pc_src = pc_sel;
  assign flush  = (pc_sel != PC_SEQ) & ~stall;

  logic [4:0]  rd_q, rd_d;
  logic        rw_q, rw_d;
  logic [1:0]  mrp_q, mrp_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] pcinc_q, pcinc_d;

  // An aborted access retires as a bubble even though the stall is released.
  always_comb begin
    rd_d    = 5'd0;
    rw_d    = 1'b0;
    mrp_d   = mrp_q;
    alu_d   = alu_q;
    rdata_d = rdata_q;
    pcinc_d = pcinc_q;
    if (!(stall | abort)) begin
      rd_d    = ex_mem_rd;
      rw_d    = reg_write;
      mrp_d   = mem_reg_pc;
      alu_d   = alu_out;
      pcinc_d = pc_inc;
      if (ack_accept) rdata_d = dmem_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q    <= '0;
      rw_q    <= 1'b0;
      mrp_q   <= '0;
      alu_q   <= '0;
      rdata_q <= '0;
      pcinc_q <= '0;
    end else begin
      rd_q    <= rd_d;
      rw_q    <= rw_d;
      mrp_q   <= mrp_d;
      alu_q   <= alu_d;
      rdata_q <= rdata_d;
      pcinc_q <= pcinc_d;
    end
  end

  assign mem_wb_rd         = rd_q;
  assign mem_wb_reg_write  = rw_q;
  assign mem_wb_mem_reg_pc = mrp_q;
  assign mem_wb_alu_out    = alu_q;
  assign mem_wb_read_data  = rdata_q;
  assign mem_wb_pc_inc     = pcinc_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (TIMEOUT=4): vector table for redirects and
// single-cycle ops, hand sequences for load/store/timeout/reset corner cases.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  ex_mem_rd;
  logic        reg_write;
  logic [1:0]  mem_reg_pc;
  logic        mem_read, mem_write;
  logic        jl, jlr, branch, zero;
  logic [31:0] pc_inc, pc_plus_imm, alu_out, read_data_2;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        stall, flush, bus_err;
  logic [1:0]  pc_src;
  logic [31:0] pc_target;
  logic [4:0]  mem_wb_rd;
  logic        mem_wb_reg_write;
  logic [1:0]  mem_wb_mem_reg_pc;
  logic [31:0] mem_wb_alu_out, mem_wb_read_data, mem_wb_pc_inc;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .ex_mem_rd         (ex_mem_rd),
    .reg_write         (reg_write),
    .mem_reg_pc        (mem_reg_pc),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .jl                (jl),
    .jlr               (jlr),
    .branch            (branch),
    .pc_inc            (pc_inc),
    .pc_plus_imm       (pc_plus_imm),
    .alu_out           (alu_out),
    .read_data_2       (read_data_2),
    .zero              (zero),
    .dmem_req          (dmem_req),
    .dmem_we           (dmem_we),
    .dmem_addr         (dmem_addr),
    .dmem_wdata        (dmem_wdata),
    .dmem_rdata        (dmem_rdata),
    .dmem_ack          (dmem_ack),
    .stall             (stall),
    .pc_src            (pc_src),
    .pc_target         (pc_target),
    .flush             (flush),
    .bus_err           (bus_err),
    .mem_wb_rd         (mem_wb_rd),
    .mem_wb_reg_write  (mem_wb_reg_write),
    .mem_wb_mem_reg_pc (mem_wb_mem_reg_pc),
    .mem_wb_alu_out    (mem_wb_alu_out),
    .mem_wb_read_data  (mem_wb_read_data),
    .mem_wb_pc_inc     (mem_wb_pc_inc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        jl, jlr, branch, zero;
    logic [4:0]  rd;
    logic        rw;
    logic [1:0]  mrp;
    logic [31:0] pc_inc, ppi, alu;
    logic [1:0]  exp_src;
    logic [31:0] exp_tgt;
    logic        exp_flush;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic rd_rw, input logic [4:0] rd, input logic [1:0] mrp,
                           input logic rd_op, input logic wr_op, input logic [31:0] alu,
                           input logic [31:0] wd);
    reg_write   = rd_rw;
    ex_mem_rd   = rd;
    mem_reg_pc  = mrp;
    mem_read    = rd_op;
    mem_write   = wr_op;
    alu_out     = alu;
    read_data_2 = wd;
    jl = 1'b0; jlr = 1'b0; branch = 1'b0; zero = 1'b0;
  endtask

  initial begin
    //          jl   jlr  br   z    rd     rw   mrp    pc_inc        ppi           alu           src    tgt           flush
    vecs[0] = '{1'b0,1'b0,1'b0,1'b0,5'd5, 1'b1,2'b00, 32'h0000_0008,32'h0000_0000,32'h0000_1234,2'b00, 32'h0000_0008,1'b0};
    vecs[1] = '{1'b0,1'b0,1'b1,1'b1,5'd0, 1'b0,2'b00, 32'h0000_000C,32'h0000_0040,32'h0000_0000,2'b01, 32'h0000_0040,1'b1};
    vecs[2] = '{1'b0,1'b0,1'b1,1'b0,5'd0, 1'b0,2'b00, 32'h0000_0010,32'h0000_0040,32'h0000_0001,2'b00, 32'h0000_0010,1'b0};
    vecs[3] = '{1'b0,1'b1,1'b0,1'b0,5'd1, 1'b1,2'b10, 32'h0000_0014,32'h0000_0999,32'h0000_0081,2'b10, 32'h0000_0080,1'b1};
    vecs[4] = '{1'b1,1'b0,1'b0,1'b0,5'd31,1'b1,2'b10, 32'h0000_0018,32'h0000_0200,32'h0000_0555,2'b01, 32'h0000_0200,1'b1};
    vecs[5] = '{1'b0,1'b1,1'b1,1'b1,5'd2, 1'b1,2'b10, 32'h0000_001C,32'h0000_0300,32'hFFFF_FFFF,2'b10, 32'hFFFF_FFFE,1'b1};
    vecs[6] = '{1'b0,1'b0,1'b0,1'b1,5'd4, 1'b1,2'b00, 32'h0000_0020,32'h0000_0077,32'h0000_00AB,2'b00, 32'h0000_0020,1'b0};

    reset = 1'b1;
    set_instr(1'b0, 5'd0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
    pc_inc = 32'h0; pc_plus_imm = 32'h0; dmem_rdata = 32'h0; dmem_ack = 1'b0;
    #12;
    chk("rst_req",      32'(dmem_req), 32'd0);
    chk("rst_we",       32'(dmem_we), 32'd0);
    chk("rst_addr",     dmem_addr, 32'd0);
    chk("rst_bus_err",  32'(bus_err), 32'd0);
    chk("rst_wb_rd",    32'(mem_wb_rd), 32'd0);
    chk("rst_wb_rw",    32'(mem_wb_reg_write), 32'd0);
    chk("rst_wb_alu",   mem_wb_alu_out, 32'd0);
    chk("rst_wb_rdata", mem_wb_read_data, 32'd0);
    chk("rst_stall",    32'(stall), 32'd0);
    reset = 1'b0;

    // Single-cycle ops and redirects.
    for (int i = 0; i < NV; i++) begin
      set_instr(vecs[i].rw, vecs[i].rd, vecs[i].mrp, 1'b0, 1'b0, vecs[i].alu, 32'h0);
      jl = vecs[i].jl; jlr = vecs[i].jlr; branch = vecs[i].branch; zero = vecs[i].zero;
      pc_inc = vecs[i].pc_inc; pc_plus_imm = vecs[i].ppi;
      #1;
      chk($sformatf("v%0d_stall", i), 32'(stall), 32'd0);
      chk($sformatf("v%0d_pc_src", i), 32'(pc_src), 32'(vecs[i].exp_src));
      chk($sformatf("v%0d_pc_target", i), pc_target, vecs[i].exp_tgt);
      chk($sformatf("v%0d_flush", i), 32'(flush), 32'(vecs[i].exp_flush));
      tick();
      chk($sformatf("v%0d_wb_rd", i), 32'(mem_wb_rd), 32'(vecs[i].rd));
      chk($sformatf("v%0d_wb_rw", i), 32'(mem_wb_reg_write), 32'(vecs[i].rw));
      chk($sformatf("v%0d_wb_mrp", i), 32'(mem_wb_mem_reg_pc), 32'(vecs[i].mrp));
      chk($sformatf("v%0d_wb_alu", i), mem_wb_alu_out, vecs[i].alu);
      chk($sformatf("v%0d_wb_pcinc", i), mem_wb_pc_inc, vecs[i].pc_inc);
    end

    // Load, ack on the 3rd WAIT cycle.
    set_instr(1'b1, 5'd7, 2'b01, 1'b1, 1'b0, 32'h0000_0100, 32'h0);
    pc_inc = 32'h0000_0104;
    #1;
    chk("ld_idle_stall", 32'(stall), 32'd1);
    chk("ld_idle_req", 32'(dmem_req), 32'd0);
    tick();
    chk("ld_w1_req", 32'(dmem_req), 32'd1);
    chk("ld_w1_we", 32'(dmem_we), 32'd0);
    chk("ld_w1_addr", dmem_addr, 32'h0000_0100);
    chk("ld_w1_wb_rw", 32'(mem_wb_reg_write), 32'd0);
    chk("ld_w1_wb_rd", 32'(mem_wb_rd), 32'd0);
    chk("ld_w1_stall", 32'(stall), 32'd1);
    tick();
    chk("ld_w2_stall", 32'(stall), 32'd1);
    chk("ld_w2_wb_rw", 32'(mem_wb_reg_write), 32'd0);
    tick();
    dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("ld_w3_stall", 32'(stall), 32'd0);
    tick();
    chk("ld_done_req", 32'(dmem_req), 32'd0);
    chk("ld_done_rdata", mem_wb_read_data, 32'hDEAD_BEEF);
    chk("ld_done_rw", 32'(mem_wb_reg_write), 32'd1);
    chk("ld_done_rd", 32'(mem_wb_rd), 32'd7);
    chk("ld_done_mrp", 32'(mem_wb_mem_reg_pc), 32'd1);
    chk("ld_done_bus_err", 32'(bus_err), 32'd0);

    // Back-to-back store, ack in the 1st WAIT cycle.
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    set_instr(1'b0, 5'd0, 2'b00, 1'b0, 1'b1, 32'h0000_0200, 32'hA5A5_A5A5);
    #1;
    chk("st_idle_stall", 32'(stall), 32'd1);
    tick();
    chk("st_req", 32'(dmem_req), 32'd1);
    chk("st_we", 32'(dmem_we), 32'd1);
    chk("st_addr", dmem_addr, 32'h0000_0200);
    chk("st_wdata", dmem_wdata, 32'hA5A5_A5A5);
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    #1;
    chk("st_w1_stall", 32'(stall), 32'd0);
    tick();
    chk("st_done_req", 32'(dmem_req), 32'd0);
    chk("st_done_we", 32'(dmem_we), 32'd0);
    chk("st_done_rw", 32'(mem_wb_reg_write), 32'd0);

    // Ack while IDLE is ignored: read data holds.
    set_instr(1'b1, 5'd3, 2'b00, 1'b0, 1'b0, 32'h0000_0033, 32'h0);
    dmem_rdata = 32'h5555_5555;
    tick();
    chk("idle_ack_rdata", mem_wb_read_data, 32'hCAFE_F00D);
    chk("idle_ack_req", 32'(dmem_req), 32'd0);
    chk("idle_ack_rd", 32'(mem_wb_rd), 32'd3);

    // Timeout abort after 4 WAIT cycles without ack.
    dmem_ack = 1'b0;
    set_instr(1'b1, 5'd9, 2'b01, 1'b1, 1'b0, 32'h0000_0300, 32'h0);
    tick();
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("to_w%0d_stall", k), 32'(stall), 32'd1);
      tick();
    end
    chk("to_w4_stall", 32'(stall), 32'd0);
    chk("to_w4_bus_err", 32'(bus_err), 32'd0);
    tick();
    chk("to_bus_err", 32'(bus_err), 32'd1);
    chk("to_req", 32'(dmem_req), 32'd0);
    chk("to_wb_rw", 32'(mem_wb_reg_write), 32'd0);
    chk("to_wb_rd", 32'(mem_wb_rd), 32'd0);
    set_instr(1'b0, 5'd0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("to_after_stall", 32'(stall), 32'd0);
    tick();
    chk("to_bus_err_pulse", 32'(bus_err), 32'd0);

    // Ack in the 4th WAIT cycle wins over the timeout.
    set_instr(1'b1, 5'd10, 2'b01, 1'b1, 1'b0, 32'h0000_0400, 32'h0);
    tick(); tick(); tick(); tick();
    dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
    #1;
    chk("ack4_stall", 32'(stall), 32'd0);
    tick();
    chk("ack4_bus_err", 32'(bus_err), 32'd0);
    chk("ack4_req", 32'(dmem_req), 32'd0);
    chk("ack4_rdata", mem_wb_read_data, 32'h1234_5678);
    chk("ack4_rw", 32'(mem_wb_reg_write), 32'd1);
    chk("ack4_rd", 32'(mem_wb_rd), 32'd10);

    // Reset in the middle of WAIT.
    dmem_ack = 1'b0;
    set_instr(1'b1, 5'd11, 2'b01, 1'b1, 1'b0, 32'h0000_0500, 32'h0);
    tick();
    chk("rw_req_before", 32'(dmem_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rw_req", 32'(dmem_req), 32'd0);
    chk("rw_addr", dmem_addr, 32'd0);
    chk("rw_wb_alu", mem_wb_alu_out, 32'd0);
    chk("rw_wb_rdata", mem_wb_read_data, 32'd0);
    chk("rw_wb_pcinc", mem_wb_pc_inc, 32'd0);
    chk("rw_wb_mrp", 32'(mem_wb_mem_reg_pc), 32'd0);
    #2 reset = 1'b0;
    #1;
    chk("rw_idle_stall", 32'(stall), 32'd1);
    chk("rw_idle_req", 32'(dmem_req), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
